msx_bus_sequencer: RTL and testbench
====================================

MSX_BUS_SEQUENCER -- requirements
Module: msx_bus_sequencer

Interface
REQ-001 Parameter IO_BASE, 8'h00, I/O port base matched against ADDR[7:0].
REQ-002 Parameter IO_MASK, 8'hFC, bits of ADDR[7:0] compared with IO_BASE (1 = compare).
REQ-003 Parameter TIMEOUT, 64, maximum CLK cycles from MEM_REQ assertion to MEM_ACK before abort; range 2..255.
REQ-004 CLK  in  1  system clock; single clock domain; every port is synchronous to CLK.
REQ-005 RESET  in  1  reset; synchronous and active-high.
REQ-006 ADDR, DIN  in  16, 8  filtered MSX address and write data.
REQ-007 SLTSL_n, MERQ_n, IORQ_n, M1_n, RFSH_n, RD_n, WR_n  in  1 each  filtered MSX strobes, active-low.
REQ-008 DOUT  out  8  read data presented to the cartridge data bus.
REQ-009 BUSDIR_n  out  1  low = cartridge drives data bus.
REQ-010 WAIT_n  out  1  low = insert Z80 wait states.
REQ-011 MEM_REQ, MEM_WE, MEM_IO  out  1 each  request, write flag, I/O-space flag to the backend.
REQ-012 MEM_ADDR, MEM_WDATA  out  16, 8  request address and write data.
REQ-013 MEM_ACK, MEM_RDATA  in  1, 8  backend completion pulse and read data (valid with MEM_ACK).
REQ-014 ERR  out  1  one-cycle pulse on timeout abort.

Function
REQ-015 States IDLE, REQ, DRIVE, HOLD; encoding from the shared package.
REQ-016 Start = RD_n or WR_n sampled high last cycle and low this cycle, the other strobe high, and (SLTSL_n=0, MERQ_n=0, RFSH_n=1) or (IORQ_n=0, M1_n=1, (ADDR[7:0]^IO_BASE)&IO_MASK=0).
REQ-017 IDLE->REQ on start: same edge latches MEM_ADDR=ADDR, MEM_WDATA=DIN, MEM_WE=!WR_n, MEM_IO=!IORQ_n; MEM_REQ=1 and WAIT_n=0 from next cycle.
REQ-018 RD_n and WR_n falling in the same cycle: not a start; stay IDLE.
REQ-019 REQ: MEM_REQ, MEM_* held stable until MEM_ACK; MEM_ACK outside REQ ignored.
REQ-020 REQ + MEM_ACK, read: capture MEM_RDATA into DOUT, MEM_REQ=0, WAIT_n=1 next cycle, ->DRIVE.
REQ-021 REQ + MEM_ACK, write: MEM_REQ=0, WAIT_n=1 next cycle, ->HOLD.
REQ-022 DRIVE: BUSDIR_n=0 while RD_n=0; RD_n high -> BUSDIR_n=1 next cycle, ->IDLE.
REQ-023 HOLD: wait for RD_n=1 and WR_n=1, then ->IDLE; no new start accepted until IDLE.
REQ-024 Timeout counter 8 bits, cleared on REQ entry, increments each REQ cycle; reaching TIMEOUT without MEM_ACK -> MEM_REQ=0, WAIT_n=1, ERR pulse, DOUT=8'hFF, ->DRIVE (read) or HOLD (write).
REQ-025 MEM_ACK in the same cycle as timeout: ACK wins, no ERR.
REQ-026 Strobe released while in REQ: request still completes; read then goes to HOLD, BUSDIR_n stays 1.
REQ-027 Latency: start edge to MEM_REQ = 1 cycle; MEM_ACK to WAIT_n release = 1 cycle.

Reset
REQ-028 RESET=1 at any clock edge, including mid-request: state IDLE, MEM_REQ=0, MEM_WE=0, MEM_IO=0, MEM_ADDR=0, MEM_WDATA=0, DOUT=8'hFF, BUSDIR_n=1, WAIT_n=1, ERR=0, counter 0, edge registers high.
REQ-029 Aborted request not retried after reset; MEM_ACK in the cycle after reset ignored.

Structure
REQ-030 Shared package msx_bus_pkg: state enum, DOUT_IDLE=8'hFF, default IO_BASE/IO_MASK/TIMEOUT.
REQ-031 One sub-module msx_strobe_edge: registered falling/rising-edge detect for RD_n and WR_n, reset value high.

Verification
REQ-032 Mem read: SLTSL_n=0, MERQ_n=0, ADDR=16'h4000, RD_n falls; ACK after 5 cycles, RDATA=8'hA5 -> MEM_REQ 1 cycle after edge, WAIT_n low 5 cycles, DOUT=8'hA5, BUSDIR_n=0 until RD_n rises.
REQ-033 I/O write: IORQ_n=0, ADDR[7:0]=8'h02, DIN=8'h3C, WR_n falls -> MEM_IO=1, MEM_WE=1, MEM_WDATA=8'h3C; ADDR[7:0]=8'h10 -> no request.
REQ-034 Timeout: read, no ACK, TIMEOUT=64 -> MEM_REQ drops after 64 cycles, ERR one pulse, DOUT=8'hFF, WAIT_n=1.
REQ-035 Filters: RFSH_n=0 or M1_n=0 during IORQ, or RD_n/WR_n falling together -> MEM_REQ stays 0.
REQ-036 RESET=1 two cycles after MEM_REQ -> next edge MEM_REQ=0, WAIT_n=1, BUSDIR_n=1; late MEM_ACK ignored.
REQ-037 RD_n rises while in REQ, ACK later -> no BUSDIR_n=0, return to IDLE, next read serviced normally.

Source files
------------

// File: rtl/msx_bus_pkg.sv
// msx_bus_pkg: shared state encoding and defaults for the MSX bus sequencer
package msx_bus_pkg;
  typedef enum logic [1:0] {IDLE, REQ, DRIVE, HOLD} state_t;
  localparam logic [7:0] DOUT_IDLE   = 8'hFF;
  localparam logic [7:0] IO_BASE_DEF = 8'h00;
  localparam logic [7:0] IO_MASK_DEF = 8'hFC;
  localparam int unsigned TIMEOUT_DEF = 64;
endpackage

// File: rtl/msx_strobe_edge.sv
// msx_strobe_edge: registered edge detect for RD_n/WR_n, history resets high
module msx_strobe_edge (
  input  logic clk,
  input  logic rst,
  input  logic rd_n,
  input  logic wr_n,
  output logic rd_fall,
  output logic wr_fall,
  output logic rd_rise,
  output logic wr_rise
);
  logic rd_q, rd_d, wr_q, wr_d;
  always_comb begin
    rd_d = rd_n;
    wr_d = wr_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= 1'b1;
      wr_q <= 1'b1;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
    end
  end
  assign rd_fall = rd_q & ~rd_n;
  assign wr_fall = wr_q & ~wr_n;
  assign rd_rise = ~rd_q & rd_n;
  assign wr_rise = ~wr_q & wr_n;
endmodule

// File: rtl/msx_bus_sequencer.sv
// msx_bus_sequencer: turns MSX cartridge read/write cycles into backend requests with wait insertion
module msx_bus_sequencer
  import msx_bus_pkg::*;
#(
  parameter logic [7:0]  IO_BASE = IO_BASE_DEF,
  parameter logic [7:0]  IO_MASK = IO_MASK_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] ADDR,
  input  logic [7:0]  DIN,
  input  logic        SLTSL_n,
  input  logic        MERQ_n,
  input  logic        IORQ_n,
  input  logic        M1_n,
  input  logic        RFSH_n,
  input  logic        RD_n,
  input  logic        WR_n,
  output logic [7:0]  DOUT,
  output logic        BUSDIR_n,
  output logic        WAIT_n,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic        MEM_IO,
  output logic [15:0] MEM_ADDR,
  output logic [7:0]  MEM_WDATA,
  input  logic        MEM_ACK,
  input  logic [7:0]  MEM_RDATA,
  output logic        ERR
);
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d, dout_q, dout_d, wdata_q, wdata_d;
  logic [15:0] addr_q, addr_d;
  logic req_q, req_d, we_q, we_d, io_q, io_d, wait_q, wait_d;
  logic busdir_q, busdir_d, err_q, err_d, rel_q, rel_d;
  logic rd_fall, wr_fall, rd_rise, wr_rise, start, rel_now, tmo, done;
  msx_strobe_edge u_edge (
    .clk(CLK), .rst(RESET), .rd_n(RD_n), .wr_n(WR_n),
    .rd_fall(rd_fall), .wr_fall(wr_fall), .rd_rise(rd_rise), .wr_rise(wr_rise)
  );
  assign start = ((rd_fall & WR_n) | (wr_fall & RD_n)) &
                 ((~SLTSL_n & ~MERQ_n & RFSH_n) |
                  (~IORQ_n & M1_n & (((ADDR[7:0] ^ IO_BASE) & IO_MASK) == 8'h00)));
  // a strobe released mid-request means the CPU is no longer there to receive data
  assign rel_now = rel_q | (we_q ? wr_rise : rd_rise);
  assign tmo = cnt_q == 8'(TIMEOUT - 1);
  assign done = MEM_ACK | tmo;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rel_d   = rel_q;
    req_d   = req_q;
    we_d    = we_q;
    io_d    = io_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;
    wait_d  = wait_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = REQ;
        cnt_d   = 8'd0;
        rel_d   = 1'b0;
        req_d   = 1'b1;
        wait_d  = 1'b0;
        we_d    = ~WR_n;
        io_d    = ~IORQ_n;
        addr_d  = ADDR;
        wdata_d = DIN;
      end
      REQ: begin
        rel_d = rel_now;
        cnt_d = cnt_q + 8'd1;
        if (done) begin
          req_d   = 1'b0;
          wait_d  = 1'b1;
          err_d   = ~MEM_ACK;
          dout_d  = MEM_ACK ? (we_q ? dout_q : MEM_RDATA) : DOUT_IDLE;
          state_d = (~we_q & ~rel_now) ? DRIVE : HOLD;
        end
      end
      DRIVE: state_d = RD_n ? IDLE : DRIVE;
      HOLD:  state_d = (RD_n & WR_n) ? IDLE : HOLD;
    endcase
    busdir_d = state_d != DRIVE;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      rel_q    <= 1'b0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      io_q     <= 1'b0;
      addr_q   <= 16'd0;
      wdata_q  <= 8'd0;
      dout_q   <= DOUT_IDLE;
      wait_q   <= 1'b1;
      busdir_q <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rel_q    <= rel_d;
      req_q    <= req_d;
      we_q     <= we_d;
      io_q     <= io_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      dout_q   <= dout_d;
      wait_q   <= wait_d;
      busdir_q <= busdir_d;
      err_q    <= err_d;
    end
  end
  assign DOUT      = dout_q;
  assign BUSDIR_n  = busdir_q;
  assign WAIT_n    = wait_q;
  assign MEM_REQ   = req_q;
  assign MEM_WE    = we_q;
  assign MEM_IO    = io_q;
  assign MEM_ADDR  = addr_q;
  assign MEM_WDATA = wdata_q;
  assign ERR       = err_q;
endmodule

// File: tb/tb_msx_bus_sequencer.sv
// tb_msx_bus_sequencer: vector table for request decode plus directed multi-cycle sequences
module tb_msx_bus_sequencer;
  logic CLK = 1'b0, RESET = 1'b1;
  logic [15:0] ADDR = 16'd0;
  logic [7:0] DIN = 8'd0, MEM_RDATA = 8'd0;
  logic SLTSL_n = 1'b1, MERQ_n = 1'b1, IORQ_n = 1'b1, M1_n = 1'b1, RFSH_n = 1'b1;
  logic RD_n = 1'b1, WR_n = 1'b1, MEM_ACK = 1'b0;
  logic [7:0] DOUT, MEM_WDATA;
  logic [15:0] MEM_ADDR;
  logic BUSDIR_n, WAIT_n, MEM_REQ, MEM_WE, MEM_IO, ERR;
  int errs = 0, checks = 0;

  msx_bus_sequencer dut (
    .CLK(CLK), .RESET(RESET), .ADDR(ADDR), .DIN(DIN),
    .SLTSL_n(SLTSL_n), .MERQ_n(MERQ_n), .IORQ_n(IORQ_n), .M1_n(M1_n), .RFSH_n(RFSH_n),
    .RD_n(RD_n), .WR_n(WR_n), .DOUT(DOUT), .BUSDIR_n(BUSDIR_n), .WAIT_n(WAIT_n),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_IO(MEM_IO), .MEM_ADDR(MEM_ADDR),
    .MEM_WDATA(MEM_WDATA), .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic sl, mq, io, m1, rf, rd, wr;
    logic [15:0] a;
    logic [7:0] d;
    logic req, we, isio;
  } vec_t;
  vec_t v[9];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    SLTSL_n = 1; MERQ_n = 1; IORQ_n = 1; M1_n = 1; RFSH_n = 1;
    RD_n = 1; WR_n = 1; MEM_ACK = 0;
    repeat (3) step();
  endtask

  task automatic start_rd(input logic [15:0] a);
    idle();
    SLTSL_n = 0; MERQ_n = 0; ADDR = a; RD_n = 0;
    step();
  endtask

  initial begin
    int n, e;
    v[0] = '{0, 0, 1, 1, 1, 0, 1, 16'h4000, 8'h00, 1, 0, 0};
    v[1] = '{1, 1, 0, 1, 1, 1, 0, 16'h0002, 8'h3C, 1, 1, 1};
    v[2] = '{1, 1, 0, 1, 1, 1, 0, 16'h0010, 8'h3C, 0, 0, 0};
    v[3] = '{0, 0, 1, 1, 0, 0, 1, 16'h4000, 8'h00, 0, 0, 0};
    v[4] = '{1, 1, 0, 0, 1, 0, 1, 16'h0001, 8'h00, 0, 0, 0};
    v[5] = '{0, 0, 1, 1, 1, 0, 0, 16'h4000, 8'h11, 0, 0, 0};
    v[6] = '{0, 0, 1, 1, 1, 1, 0, 16'h8123, 8'h5A, 1, 1, 0};
    v[7] = '{1, 1, 0, 1, 1, 0, 1, 16'h1203, 8'h00, 1, 0, 1};
    v[8] = '{1, 0, 1, 1, 1, 0, 1, 16'h4000, 8'h00, 0, 0, 0};

    repeat (2) step();
    MEM_ACK = 1;
    step();
    chk("rst MEM_REQ", MEM_REQ, 0);
    chk("rst WAIT_n", WAIT_n, 1);
    chk("rst BUSDIR_n", BUSDIR_n, 1);
    chk("rst DOUT", DOUT, 8'hFF);
    chk("rst ERR", ERR, 0);
    chk("rst MEM_ADDR", MEM_ADDR, 0);
    RESET = 0;
    step();
    chk("post-rst ack ignored", MEM_REQ, 0);

    for (int i = 0; i < 9; i++) begin
      idle();
      SLTSL_n = v[i].sl; MERQ_n = v[i].mq; IORQ_n = v[i].io; M1_n = v[i].m1; RFSH_n = v[i].rf;
      ADDR = v[i].a; DIN = v[i].d; RD_n = v[i].rd; WR_n = v[i].wr;
      step();
      chk($sformatf("v%0d MEM_REQ", i), MEM_REQ, v[i].req);
      chk($sformatf("v%0d WAIT_n", i), WAIT_n, !v[i].req);
      if (v[i].req) begin
        chk($sformatf("v%0d MEM_WE", i), MEM_WE, v[i].we);
        chk($sformatf("v%0d MEM_IO", i), MEM_IO, v[i].isio);
        chk($sformatf("v%0d MEM_ADDR", i), MEM_ADDR, v[i].a);
        chk($sformatf("v%0d MEM_WDATA", i), MEM_WDATA, v[i].d);
        MEM_ACK = 1;
        step();
        MEM_ACK = 0;
        chk($sformatf("v%0d req drop", i), MEM_REQ, 0);
      end
    end

    start_rd(16'h4000);
    chk("rd MEM_REQ", MEM_REQ, 1);
    n = 0;
    for (int c = 0; c < 4; c++) begin
      if (!WAIT_n) n++;
      step();
    end
    if (!WAIT_n) n++;
    MEM_ACK = 1; MEM_RDATA = 8'hA5;
    step();
    MEM_ACK = 0;
    chk("rd wait cycles", n, 5);
    chk("rd WAIT_n release", WAIT_n, 1);
    chk("rd MEM_REQ drop", MEM_REQ, 0);
    chk("rd DOUT", DOUT, 8'hA5);
    chk("rd BUSDIR_n drive", BUSDIR_n, 0);
    step();
    chk("rd BUSDIR_n held", BUSDIR_n, 0);
    RD_n = 1;
    step();
    chk("rd BUSDIR_n release", BUSDIR_n, 1);

    start_rd(16'h4100);
    n = 0; e = 0;
    for (int c = 0; c < 300 && MEM_REQ; c++) begin
      n++;
      if (ERR) e++;
      step();
    end
    chk("tmo req cycles", n, 64);
    chk("tmo early ERR", e, 0);
    chk("tmo ERR", ERR, 1);
    chk("tmo DOUT", DOUT, 8'hFF);
    chk("tmo WAIT_n", WAIT_n, 1);
    step();
    chk("tmo ERR one pulse", ERR, 0);

    start_rd(16'h4200);
    repeat (63) step();
    MEM_ACK = 1; MEM_RDATA = 8'h77;
    step();
    MEM_ACK = 0;
    chk("ack-at-tmo ERR", ERR, 0);
    chk("ack-at-tmo DOUT", DOUT, 8'h77);
    chk("ack-at-tmo MEM_REQ", MEM_REQ, 0);

    start_rd(16'h4300);
    repeat (2) step();
    RESET = 1; RD_n = 1;
    step();
    RESET = 0;
    chk("midrst MEM_REQ", MEM_REQ, 0);
    chk("midrst WAIT_n", WAIT_n, 1);
    chk("midrst BUSDIR_n", BUSDIR_n, 1);
    chk("midrst DOUT", DOUT, 8'hFF);
    MEM_ACK = 1; MEM_RDATA = 8'h12;
    step();
    MEM_ACK = 0;
    chk("late ack MEM_REQ", MEM_REQ, 0);
    chk("late ack DOUT", DOUT, 8'hFF);
    chk("late ack BUSDIR_n", BUSDIR_n, 1);

    start_rd(16'h4400);
    step();
    RD_n = 1;
    repeat (2) step();
    chk("rel still req", MEM_REQ, 1);
    MEM_ACK = 1; MEM_RDATA = 8'h5C;
    step();
    MEM_ACK = 0;
    n = 0;
    for (int c = 0; c < 4; c++) begin
      if (!BUSDIR_n) n++;
      step();
    end
    chk("rel no drive", n, 0);
    chk("rel WAIT_n", WAIT_n, 1);
    start_rd(16'h4500);
    chk("after rel MEM_REQ", MEM_REQ, 1);
    MEM_ACK = 1; MEM_RDATA = 8'h3E;
    step();
    MEM_ACK = 0;
    chk("after rel DOUT", DOUT, 8'h3E);
    chk("after rel BUSDIR_n", BUSDIR_n, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
